uart_rx_frame_param: RTL and testbench

Parametrised UART receive front end: the successor to the fixed 11-bit serial-to-parallel capture unit.
- Oversamples rx_serial on baud_clk and deserialises 5..MAX_DATA_BITS data bits, LSB first.
- Parity (none/even/odd) and 1 or 2 stop bits are selected at run time.
- Presents the payload with per-frame error flags over a valid/ready handshake to the core-side UART register block.

---
 rtl/uart_rx_frame_param.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_frame_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_param.sv
// UART receive front end: 5..MAX_DATA_BITS data bits, run-time parity/stop selection, valid/ready output.
// Optional build macro RX_MAJORITY_VOTE_EN: 2-of-3 vote over the last three synchronised samples per bit decision.
//
// state  | meaning
// IDLE   | line idle, waiting for rxs=0; frame config latched on start detection
// START  | confirming the start bit at its middle
// DATA   | shifting in data bits, LSB first
// PARITY | checking the parity bit
// STOP   | checking one or two stop bits, then delivering the frame
module uart_rx_frame_param #(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 8
) (
  input  logic                     baud_clk,
  input  logic                     reset_n,
  input  logic                     rx_serial,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_two_stop,
  input  logic                     rx_ready,
  output logic                     rx_valid,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun_err,
  output logic                     active_flag
);

  localparam int              SW     = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0]   S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0]   S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      MAX_NB = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                   state;
  logic                     sync0;
  logic                     rxs;
  logic                     bit_val;
  logic [SW-1:0]            s_cnt;
  logic [3:0]               bit_cnt;
  logic [3:0]               nbits;
  logic [3:0]               cfg_nbits;
  logic [3:0]               shamt;
  logic                     par_en;
  logic                     par_odd;
  logic                     two_stop;
  logic                     par_acc;
  logic                     perr_acc;
  logic                     ferr_acc;
  logic [MAX_DATA_BITS-1:0] shreg;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync0 <= rx_serial;
      rxs   <= sync0;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic rxs_d1;
  logic rxs_d2;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end

  assign bit_val = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  assign bit_val = rxs;
`endif

  always_comb begin
    if (cfg_data_bits < 4'd5)
      cfg_nbits = 4'd5;
    else if (cfg_data_bits > MAX_NB)
      cfg_nbits = MAX_NB;
    else
      cfg_nbits = cfg_data_bits;
  end

  // Bits enter at the MSB end, so a short frame ends up left-justified in shreg.
  assign shamt = MAX_NB - nbits;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      s_cnt       <= '0;
      bit_cnt     <= '0;
      nbits       <= '0;
      par_en      <= 1'b0;
      par_odd     <= 1'b0;
      two_stop    <= 1'b0;
      par_acc     <= 1'b0;
      perr_acc    <= 1'b0;
      ferr_acc    <= 1'b0;
      shreg       <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      active_flag <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state       <= START;
            s_cnt       <= '0;
            bit_cnt     <= '0;
            active_flag <= 1'b1;
            nbits       <= cfg_nbits;
            par_en      <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_odd     <= (cfg_parity == 2'b10);
            two_stop    <= cfg_two_stop;
            shreg       <= '0;
            par_acc     <= 1'b0;
            perr_acc    <= 1'b0;
            ferr_acc    <= 1'b0;
          end
        end

        START: begin
          if (s_cnt == S_MID) begin
            s_cnt <= '0;
            if (bit_val) begin
              state       <= IDLE;
              active_flag <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        DATA: begin
          if (s_cnt == S_LAST) begin
            s_cnt   <= '0;
            shreg   <= {bit_val, shreg[MAX_DATA_BITS-1:1]};
            par_acc <= par_acc ^ bit_val;
            if (bit_cnt == nbits - 4'd1) begin
              bit_cnt <= '0;
              state   <= par_en ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (s_cnt == S_LAST) begin
            s_cnt    <= '0;
            perr_acc <= par_odd ? ~(par_acc ^ bit_val) : (par_acc ^ bit_val);
            state    <= STOP;
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        STOP: begin
          if (s_cnt == S_LAST) begin
            s_cnt <= '0;
            if (two_stop && (bit_cnt == 4'd0)) begin
              bit_cnt  <= 4'd1;
              ferr_acc <= ferr_acc | ~bit_val;
            end else begin
              // Back to IDLE at mid-stop so the next start edge is not missed.
              bit_cnt     <= '0;
              rx_data     <= shreg >> shamt;
              parity_err  <= perr_acc;
              frame_err   <= ferr_acc | ~bit_val;
              rx_valid    <= 1'b1;
              overrun_err <= rx_valid & ~rx_ready;
              active_flag <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_param.sv
// Self-checking bench for uart_rx_frame_param: frame-level model plus directed literal checks.
module tb_uart_rx_frame_param;

  logic       baud_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_two_stop = 1'b0;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       active_flag;

  uart_rx_frame_param #(.OVERSAMPLE(16), .MAX_DATA_BITS(8)) dut (
    .baud_clk(baud_clk),
    .reset_n(reset_n),
    .rx_serial(rx_serial),
    .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity),
    .cfg_two_stop(cfg_two_stop),
    .rx_ready(rx_ready),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .active_flag(active_flag)
  );

  always #5 baud_clk = ~baud_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: each frame is a start edge, a completion edge and its expected result.
  typedef struct {
    int         start_cyc;
    int         end_cyc;
    bit         deliver;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t     q[$];
  logic       exp_valid = 1'b0;
  logic       exp_active = 1'b0;
  logic       exp_ovr = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_perr = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       m_acc;

  always @(posedge baud_clk) begin
    cyc = cyc + 1;
    exp_ovr = 1'b0;
    if (!reset_n) begin
      q.delete();
      exp_valid  = 1'b0;
      exp_active = 1'b0;
      exp_data   = 8'h00;
      exp_perr   = 1'b0;
      exp_ferr   = 1'b0;
    end else begin
      m_acc = exp_valid && rx_ready;
      if (m_acc) exp_valid = 1'b0;
      if (q.size() > 0 && q[0].end_cyc == cyc) begin
        exp_active = 1'b0;
        if (q[0].deliver) begin
          exp_ovr   = exp_valid;
          exp_valid = 1'b1;
          exp_data  = q[0].data;
          exp_perr  = q[0].perr;
          exp_ferr  = q[0].ferr;
        end
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].start_cyc == cyc) exp_active = 1'b1;
    end
  end

  always @(negedge baud_clk) begin
    if (!reset_n) begin
      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_active", 32'(active_flag), 32'd0);
      chk("rst_data", 32'(rx_data), 32'd0);
    end else begin
      chk("valid", 32'(rx_valid), 32'(exp_valid));
      chk("active", 32'(active_flag), 32'(exp_active));
      chk("overrun", 32'(overrun_err), 32'(exp_ovr));
      if (exp_valid) begin
        chk("data", 32'(rx_data), 32'(exp_data));
        chk("parity_err", 32'(parity_err), 32'(exp_perr));
        chk("frame_err", 32'(frame_err), 32'(exp_ferr));
      end
    end
  end

  int         rise_cyc = 0;
  int         fall_cyc = 0;
  int         valid_rises = 0;
  int         act_rises = 0;
  int         ovr_cnt = 0;
  logic [7:0] rise_data = 8'h00;
  logic       rise_perr = 1'b0;
  logic       rise_ferr = 1'b0;
  logic       v_prev = 1'b0;
  logic       a_prev = 1'b0;

  always @(negedge baud_clk) begin
    if (rx_valid && !v_prev) begin
      rise_cyc  = cyc;
      rise_data = rx_data;
      rise_perr = parity_err;
      rise_ferr = frame_err;
      valid_rises++;
    end
    if (!rx_valid && v_prev) fall_cyc = cyc;
    if (active_flag && !a_prev) act_rises++;
    if (overrun_err) ovr_cnt++;
    v_prev = rx_valid;
    a_prev = active_flag;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge baud_clk);
      #2;
    end
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    for (int c = 0; c < 16; c++) begin
      rx_serial = (glitch && c == 8) ? ~v : v;
      @(posedge baud_clk);
      #2;
    end
  endtask

  // Called at posedge+2; the first start-bit level is captured on the next edge (e).
  task automatic send_frame(input logic [7:0] data, input logic [3:0] nb, input logic [1:0] par,
                            input logic ts, input logic bad_par, input logic stop1,
                            input logic stop2, input int glitch_bit, output int e);
    int         nbe;
    int         total;
    logic       pen;
    logic       pbit;
    logic       x;
    logic [7:0] m;
    frame_t     f;
    frame_t     fs;
    nbe  = (nb < 4'd5) ? 5 : (nb > 4'd8) ? 8 : int'(nb);
    pen  = (par == 2'b01) || (par == 2'b10);
    m    = 8'((1 << nbe) - 1);
    pbit = ((par == 2'b10) ? ~(^(data & m)) : ^(data & m)) ^ bad_par;
    x    = (^(data & m)) ^ pbit;
    e    = cyc + 1;
    total       = nbe + int'(pen) + 1 + int'(ts);
    f.start_cyc = e + 2;
    f.end_cyc   = e + 10 + 16 * total;
    f.deliver   = 1'b1;
    f.data      = data & m;
    f.perr      = pen && ((par == 2'b01) ? x : !x);
    f.ferr      = !stop1 || (ts && !stop2);
    q.push_back(f);
    // A low final stop bit is still low when IDLE resumes: expect a false start.
    if (!(ts ? stop2 : stop1)) begin
      fs.start_cyc = f.end_cyc + 1;
      fs.end_cyc   = f.end_cyc + 9;
      fs.deliver   = 1'b0;
      fs.data      = 8'h00;
      fs.perr      = 1'b0;
      fs.ferr      = 1'b0;
      q.push_back(fs);
    end
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_two_stop  = ts;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < nbe; i++) drive_bit(data[i], i == glitch_bit);
    if (pen) drive_bit(pbit, 1'b0);
    drive_bit(stop1, 1'b0);
    if (ts) drive_bit(stop2, 1'b0);
    rx_serial = 1'b1;
  endtask

  int     e;
  int     a0;
  int     v0;
  int     o0;
  int     n;
  frame_t g;

  initial begin
    idle(3);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_data", 32'(rx_data), 32'd0);
    chk("reset_active", 32'(active_flag), 32'd0);
    chk("reset_overrun", 32'(overrun_err), 32'd0);
    reset_n = 1'b1;
    idle(5);

    // 8N1 0xA5: valid rises 2 sync cycles + 152 after the first low sample.
    rx_ready = 1'b1;
    send_frame(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, e);
    chk("a5_latency", 32'(rise_cyc), 32'(e + 154));
    chk("a5_data", 32'(rise_data), 32'hA5);
    chk("a5_perr", 32'(rise_perr), 32'd0);
    chk("a5_ferr", 32'(rise_ferr), 32'd0);
    chk("a5_one_cycle", 32'(fall_cyc), 32'(e + 155));
    idle(4);

    // 7E1 0x35 (four ones) with parity bit 1 -> error; 7O1 with correct bit 1 -> none.
    send_frame(8'h35, 4'd7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, -1, e);
    chk("even_latency", 32'(rise_cyc), 32'(e + 154));
    chk("even_data", 32'(rise_data), 32'h35);
    chk("even_perr", 32'(rise_perr), 32'd1);
    idle(4);
    send_frame(8'h35, 4'd7, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, -1, e);
    chk("odd_data", 32'(rise_data), 32'h35);
    chk("odd_perr", 32'(rise_perr), 32'd0);
    idle(4);

    // 8N2 with second stop low.
    send_frame(8'h3C, 4'd8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, -1, e);
    chk("n2_latency", 32'(rise_cyc), 32'(e + 170));
    chk("n2_data", 32'(rise_data), 32'h3C);
    chk("n2_ferr", 32'(rise_ferr), 32'd1);
    idle(20);

    // Four-cycle low glitch on idle line.
    a0 = act_rises;
    v0 = valid_rises;
    e = cyc + 1;
    g.start_cyc = e + 2;
    g.end_cyc   = e + 10;
    g.deliver   = 1'b0;
    g.data      = 8'h00;
    g.perr      = 1'b0;
    g.ferr      = 1'b0;
    q.push_back(g);
    rx_serial = 1'b0;
    idle(4);
    rx_serial = 1'b1;
    idle(30);
    chk("glitch_active_pulses", 32'(act_rises - a0), 32'd1);
    chk("glitch_no_valid", 32'(valid_rises - v0), 32'd0);

    // Back-to-back frames with consumer stalled.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, e);
    send_frame(8'h22, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, e);
    chk("b2b_data", 32'(rx_data), 32'h22);
    chk("b2b_valid", 32'(rx_valid), 32'd1);
    chk("b2b_overruns", 32'(ovr_cnt - o0), 32'd1);
    rx_ready = 1'b1;
    n = cyc + 1;
    while (cyc < n) @(negedge baud_clk);
    chk("b2b_accept_clears", 32'(rx_valid), 32'd0);
    @(posedge baud_clk);
    #2;
    idle(4);

    // Reset in the middle of the data field.
    e = cyc + 1;
    g.start_cyc = e + 2;
    g.end_cyc   = 1000000000;
    q.push_back(g);
    rx_serial = 1'b0;
    idle(40);
    rx_serial = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("midreset_data", 32'(rx_data), 32'd0);
    chk("midreset_active", 32'(active_flag), 32'd0);
    chk("midreset_valid", 32'(rx_valid), 32'd0);
    idle(3);
    reset_n = 1'b1;
    idle(20);
    send_frame(8'h5A, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, e);
    chk("after_reset_latency", 32'(rise_cyc), 32'(e + 154));
    chk("after_reset_data", 32'(rise_data), 32'h5A);
    idle(4);

    // Data-bit count clamping at both ends.
    send_frame(8'h1B, 4'd2, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, e);
    chk("clamp_lo_latency", 32'(rise_cyc), 32'(e + 106));
    chk("clamp_lo_data", 32'(rise_data), 32'h1B);
    idle(4);
    send_frame(8'hE7, 4'd15, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, e);
    chk("clamp_hi_latency", 32'(rise_cyc), 32'(e + 154));
    chk("clamp_hi_data", 32'(rise_data), 32'hE7);
    idle(4);

`ifdef RX_MAJORITY_VOTE_EN
    // Single-cycle inversion on bit 2's decision sample is voted out.
    send_frame(8'hC3, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2, e);
    chk("vote_data", 32'(rise_data), 32'hC3);
    idle(4);
`endif

    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
